// File: rtl/down_timer.sv
// Loadable down-counter/timer: load a start value, decrement on enab, pulse tc at expiry.
// Optional periodic mode via `define DOWN_TIMER_AUTORELOAD_EN (reload value restored on expiry).
module down_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             tc
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            cnt_d   = cnt_in;
            state_d = (cnt_in != ZERO) ? RUN : IDLE;
`ifdef DOWN_TIMER_AUTORELOAD_EN
            reload_d = cnt_in;
`endif
        end else if (state_q == RUN && enab) begin
            if (cnt_q > ONE) begin
                cnt_d = cnt_q - ONE;
            end else begin
                // Expiry: RUN never holds 0, so this is the 1 -> expiry step.
                tc_d = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                cnt_d = reload_q;
`else
                cnt_d   = ZERO;
                state_d = IDLE;
`endif
            end
        end
    end

    assign cnt_out = cnt_q;
    assign busy    = (state_q == RUN);
    assign tc      = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer (WIDTH=5): inputs driven at negedge, outputs checked at next negedge.
// Build with +define+DOWN_TIMER_AUTORELOAD_EN to cover the periodic variant.
module tb_down_timer;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst;
    logic             load;
    logic             enab;
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] cnt_out;
    logic             busy;
    logic             tc;

    int n_checks;
    int n_errors;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .enab   (enab),
        .cnt_in (cnt_in),
        .cnt_out(cnt_out),
        .busy   (busy),
        .tc     (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [WIDTH-1:0] exp_cnt,
                              input logic exp_tc, input logic exp_busy);
        check_val({tag, ".cnt"},  32'(cnt_out), 32'(exp_cnt));
        check_val({tag, ".tc"},   32'(tc),      32'(exp_tc));
        check_val({tag, ".busy"}, 32'(busy),    32'(exp_busy));
    endtask

    // Apply one cycle of inputs at the current negedge; return at the next negedge.
    task automatic step(input logic l, input logic e, input logic [WIDTH-1:0] v);
        load   = l;
        enab   = e;
        cnt_in = v;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        load   = 1'b1;
        enab   = 1'b1;
        cnt_in = 5'h15;

        // 1: reset state with active inputs
        @(negedge clk);
        @(negedge clk);
        check_outs("rst_hold", 5'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0, 5'h00);
        check_outs("rst_release", 5'h00, 1'b0, 1'b0);

        // 1b: reset asserted mid-count clears immediately
        step(1'b1, 1'b0, 5'h0A);
        check_outs("mid_load", 5'h0A, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'h00);
        step(1'b0, 1'b1, 5'h00);
        check_outs("mid_count", 5'h08, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 check_outs("mid_rst_async", 5'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 5'h00);
        check_outs("post_rst", 5'h00, 1'b0, 1'b0);

        // 2: load 3 and count to expiry
        step(1'b1, 1'b0, 5'h03);
        check_outs("t2_load", 5'h03, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'h00);
        check_outs("t2_e1", 5'h02, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'h00);
        check_outs("t2_e2", 5'h01, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'h00);
`ifdef DOWN_TIMER_AUTORELOAD_EN
        check_outs("t2_e3", 5'h03, 1'b1, 1'b1);
        step(1'b1, 1'b0, 5'h00);
        check_outs("t2_stop", 5'h00, 1'b0, 1'b0);
`else
        check_outs("t2_e3", 5'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'h00);
        check_outs("t2_after", 5'h00, 1'b0, 1'b0);
`endif

        // 3: enab gaps hold the count
        step(1'b1, 1'b0, 5'h05);
        check_outs("t3_load", 5'h05, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'h00);
        check_outs("t3_e1", 5'h04, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'h00);
        check_outs("t3_e2", 5'h03, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'h00);
        check_outs("t3_h1", 5'h03, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'h1C);
        check_outs("t3_h2_cnt_in_ignored", 5'h03, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'h00);
        check_outs("t3_e3", 5'h02, 1'b0, 1'b1);

        // 4: load coincident with expiry wins
        step(1'b0, 1'b1, 5'h00);
        check_outs("t4_at1", 5'h01, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'h1F);
        check_outs("t4_load_wins", 5'h1F, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'h00);
        check_outs("t4_next", 5'h1E, 1'b0, 1'b1);

        // 5: load 0 goes idle and never underflows
        step(1'b1, 1'b0, 5'h00);
        check_outs("t5_load0", 5'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'h00);
        check_outs("t5_e1", 5'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'h00);
        check_outs("t5_e2", 5'h00, 1'b0, 1'b0);

        // 6: load 2 then six enabled edges
        step(1'b1, 1'b0, 5'h02);
        check_outs("t6_load", 5'h02, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 5'h00);
`ifdef DOWN_TIMER_AUTORELOAD_EN
            check_outs($sformatf("t6_e%0d", i), (i % 2 == 0) ? 5'h01 : 5'h02,
                       (i % 2 == 1), 1'b1);
`else
            check_outs($sformatf("t6_e%0d", i), (i == 0) ? 5'h01 : 5'h00,
                       (i == 1), (i == 0));
`endif
        end
        step(1'b1, 1'b0, 5'h00);
        check_outs("t6_load0", 5'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
